// File: rtl/dac_serial_writer.sv
// FIFO-buffered MSB-first SYN/SCLK/DIN frame writer; pop-to-SYN-fall 1 clk, wr_ready = FIFO not full.
// Optional power-up init frame of INIT_WORD when DAC_WR_INIT_EN is defined.
module dac_serial_writer #(
  parameter int          WORD_W    = 32,
  parameter int          DIV       = 1,
  parameter int          DEPTH     = 4,
  parameter int          GAP_CYC   = 2,
  parameter logic [63:0] INIT_WORD = 64'h0000_0000_0800_0001
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  input  logic [WORD_W-1:0]        wr_data,
  output logic                     wr_ready,
  output logic                     DIN,
  output logic                     SCLK,
  output logic                     SYN,
  output logic                     over,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(WORD_W) + 1;
  localparam int HW = $clog2(DIV) + 1;
  localparam int GW = $clog2(GAP_CYC) + 1;

  localparam logic [HW-1:0]     HC_LAST  = HW'(DIV - 1);
  localparam logic [GW-1:0]     GC_LAST  = GW'((GAP_CYC > 1) ? GAP_CYC - 2 : 0);
  localparam logic [BW-1:0]     BC_DONE  = BW'(WORD_W);
  localparam logic [BW-1:0]     BC_LASTB = BW'(WORD_W - 1);
  localparam logic [LW-1:0]     LVL_FULL = LW'(DEPTH);
  localparam logic [WORD_W-1:0] INIT_VAL = INIT_WORD[WORD_W-1:0];

`ifdef DAC_WR_INIT_EN
  localparam logic INIT_RST = 1'b1;
`else
  localparam logic INIT_RST = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, END, GAP} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wp_q, rp_q;
  logic [LW-1:0]     level_q, level_d;
  logic              rdy_q;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic [BW-1:0]     bc_q, bc_d;
  logic [HW-1:0]     hc_q, hc_d;
  logic [GW-1:0]     gc_q, gc_d;
  logic              init_pend_q, init_pend_d;
  logic              din_q, din_d;
  logic              sclk_q, syn_q, over_q, busy_q;
  logic              push, pop, in_frame;
  logic [WORD_W-1:0] load_word;

  assign push      = wr_valid && rdy_q;
  assign pop       = (state_q == IDLE) && !init_pend_q && (level_q != '0);
  assign load_word = init_pend_q ? INIT_VAL : mem_q[rp_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= wr_data;
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (!push && pop) level_d = level_q - LW'(1);
  end

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bc_d        = bc_q;
    hc_d        = hc_q;
    gc_d        = gc_q;
    din_d       = din_q;
    init_pend_d = init_pend_q;
    case (state_q)
      IDLE: begin
        if (init_pend_q || (level_q != '0)) begin
          sr_d        = load_word;
          din_d       = load_word[WORD_W-1];
          bc_d        = '0;
          hc_d        = '0;
          init_pend_d = 1'b0;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        if (hc_q == HC_LAST) begin
          hc_d    = '0;
          state_d = LOW;
        end else begin
          hc_d = hc_q + HW'(1);
        end
      end
      LOW: begin
        if (hc_q == HC_LAST) begin
          hc_d    = '0;
          bc_d    = bc_q + BW'(1);
          state_d = HIGH;
          // After the final bit DIN holds until SYN rises.
          if (bc_q != BC_LASTB) begin
            sr_d  = sr_q << 1;
            din_d = sr_q[WORD_W-2];
          end
        end else begin
          hc_d = hc_q + HW'(1);
        end
      end
      HIGH: begin
        if (hc_q == HC_LAST) begin
          hc_d    = '0;
          state_d = (bc_q == BC_DONE) ? END : LOW;
        end else begin
          hc_d = hc_q + HW'(1);
        end
      end
      END: begin
        gc_d    = '0;
        state_d = (GAP_CYC > 1) ? GAP : IDLE;
      end
      GAP: begin
        if (gc_q == GC_LAST) state_d = IDLE;
        else                 gc_d    = gc_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase
    in_frame = (state_d == SETUP) || (state_d == LOW) || (state_d == HIGH);
    if (!in_frame) din_d = 1'b0;
  end

  // Pins are decoded from the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wp_q        <= '0;
      rp_q        <= '0;
      level_q     <= '0;
      rdy_q       <= 1'b0;
      sr_q        <= '0;
      bc_q        <= '0;
      hc_q        <= '0;
      gc_q        <= '0;
      init_pend_q <= INIT_RST;
      din_q       <= 1'b0;
      sclk_q      <= 1'b1;
      syn_q       <= 1'b1;
      over_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      if (push) wp_q <= wp_q + AW'(1);
      if (pop)  rp_q <= rp_q + AW'(1);
      level_q     <= level_d;
      rdy_q       <= (level_d != LVL_FULL);
      sr_q        <= sr_d;
      bc_q        <= bc_d;
      hc_q        <= hc_d;
      gc_q        <= gc_d;
      init_pend_q <= init_pend_d;
      din_q       <= din_d;
      sclk_q      <= (state_d != LOW);
      syn_q       <= !in_frame;
      over_q      <= (state_d == END);
      busy_q      <= (level_d != '0) || (state_d != IDLE) || init_pend_d;
    end
  end

  assign wr_ready = rdy_q;
  assign DIN      = din_q;
  assign SCLK     = sclk_q;
  assign SYN      = syn_q;
  assign over     = over_q;
  assign busy     = busy_q;
  assign level    = level_q;

endmodule
